// File: rtl/hp35_is_injector.sv
// hp35_is_injector
// Debug-side scheduler for the shared HP-35 IS bus. It tracks word timing from SYNC
// and captures every instruction word that appears on IS. On host request it takes
// the bus from the ROMs for exactly one SYNC window and serializes the host word,
// bit 0 first, then hands the bus back to the ROMs.

module hp35_is_injector #(
    parameter int WORD_BITS   = 56,
    parameter int INSTR_BITS  = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  PHI2,
    input  logic                  PWO_N,
    input  logic                  sync,
    input  logic                  is_obs,
    input  logic                  inj_valid,
    input  logic [INSTR_BITS-1:0] inj_data,
    output logic                  inj_ready,
    output logic                  inj_done,
    output logic                  inj_err,
    output logic                  is_in,
    output logic                  dbg_enable_rom,
    output logic                  cap_valid,
    output logic [INSTR_BITS-1:0] cap_data,
    output logic                  locked
);

    localparam int PW = $clog2(WORD_BITS);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] POS_LAST  = PW'(WORD_BITS - 1);
    localparam logic [PW-1:0] POS_WIN   = PW'(INSTR_BITS);
    localparam logic [PW-1:0] POS_WLAST = PW'(INSTR_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } state_t;

    state_t                state;
    logic [PW-1:0]         pos;
    logic                  sync_q;
    logic                  sync_rise;
    logic                  in_window;
    logic                  lock_next;
    logic                  still_locked;
    logic [INSTR_BITS-2:0] shadow;
    logic                  win_ok;
    logic [INSTR_BITS-1:0] shreg;
    logic [TW-1:0]         tcnt;

    // Next lock state; still_locked means "locked now and this cycle is consistent with SYNC"
    always_comb begin
        sync_rise = sync & ~sync_q;
        in_window = (pos < POS_WIN);
        lock_next = locked;
        if (sync_rise) begin
            lock_next = (pos == '0);
        end else if (locked && (sync != in_window)) begin
            lock_next = 1'b0;
        end
        still_locked = locked & lock_next;
    end

    // Bit-time counter re-aligned on every SYNC rise, plus the lock flag
    always_ff @(posedge PHI2 or negedge PWO_N) begin
        if (!PWO_N) begin
            sync_q <= 1'b0;
            pos    <= '0;
            locked <= 1'b0;
        end else begin
            sync_q <= sync;
            locked <= lock_next;
            if (sync_rise) begin
                pos <= PW'(1);
            end else if (pos == POS_LAST) begin
                pos <= '0;
            end else begin
                pos <= pos + 1'b1;
            end
        end
    end

    // Capture a word only if every bit of its window was seen while locked
    always_ff @(posedge PHI2 or negedge PWO_N) begin
        if (!PWO_N) begin
            shadow    <= '0;
            win_ok    <= 1'b0;
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            if (in_window) begin
                if (still_locked) begin
                    shadow <= {is_obs, shadow[INSTR_BITS-2:1]};
                end
                win_ok <= (pos == '0) ? still_locked : (win_ok & still_locked);
                if ((pos == POS_WLAST) && win_ok && still_locked) begin
                    cap_data  <= {is_obs, shadow};
                    cap_valid <= 1'b1;
                end
            end
        end
    end

    // Injection sequencer: wait for the word boundary, own the bus for one window, release
    always_ff @(posedge PHI2 or negedge PWO_N) begin
        if (!PWO_N) begin
            state          <= IDLE;
            inj_ready      <= 1'b1;
            inj_done       <= 1'b0;
            inj_err        <= 1'b0;
            is_in          <= 1'b0;
            dbg_enable_rom <= 1'b1;
            shreg          <= '0;
            tcnt           <= '0;
        end else begin
            inj_done <= 1'b0;
            inj_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (inj_valid && inj_ready) begin
                        shreg     <= inj_data;
                        tcnt      <= '0;
                        inj_ready <= 1'b0;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (still_locked && (pos == POS_LAST)) begin
                        dbg_enable_rom <= 1'b0;
                        is_in          <= shreg[0];
                        shreg          <= shreg >> 1;
                        state          <= SHIFT;
                    end else if (!still_locked) begin
                        if (tcnt == TMO_LAST) begin
                            inj_err   <= 1'b1;
                            inj_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!still_locked) begin
                        is_in          <= 1'b0;
                        dbg_enable_rom <= 1'b1;
                        inj_err        <= 1'b1;
                        inj_ready      <= 1'b1;
                        state          <= IDLE;
                    end else if (pos == POS_WLAST) begin
                        is_in          <= 1'b0;
                        dbg_enable_rom <= 1'b1;
                        inj_done       <= 1'b1;
                        inj_ready      <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        is_in <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                default: begin
                    is_in          <= 1'b0;
                    dbg_enable_rom <= 1'b1;
                    inj_ready      <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
